// File: rtl/irrig_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | irrig_pkg : shared types and constants for the irrigation controller       |
// | Rev 1.0   : initial release                                                |
// +----------------------------------------------------------------------------+
package irrig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPRINKLE = 3'd1,
    ST_DRIP     = 3'd2,
    ST_REST     = 3'd3,
    ST_FAULT    = 3'd4
  } irrig_state_e;

  localparam int C_CNT_W          = 8;
  localparam int C_MIN_RUN_DEF    = 4;
  localparam int C_MAX_RUN_DEF    = 10;
  localparam int C_REST_TICKS_DEF = 3;
  localparam int C_FLT_TICKS_DEF  = 2;
  localparam int C_FILL_TOUT_DEF  = 20;

  function automatic logic [C_CNT_W-1:0] sat_inc(input logic [C_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irrigation_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | irrigation_ctrl_if : sensor inputs and actuator outputs of irrigation_ctrl |
// | Rev 1.0            : initial release                                       |
// +----------------------------------------------------------------------------+
interface irrigation_ctrl_if;
  logic       tick;
  logic       low;
  logic       mid;
  logic       high;
  logic       erro_medida;
  logic       temp;
  logic       usolo;
  logic       uar;
  logic       aspersor;
  logic       gotejamento;
  logic       v_entrada;
  logic       alarme;
  logic [2:0] state;

  modport master (
    output tick, low, mid, high, erro_medida, temp, usolo, uar,
    input  aspersor, gotejamento, v_entrada, alarme, state
  );

  modport slave (
    input  tick, low, mid, high, erro_medida, temp, usolo, uar,
    output aspersor, gotejamento, v_entrada, alarme, state
  );
endinterface
`default_nettype wire

// File: rtl/irrig_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | irrig_debounce : tick-qualified stability filter, flips after FLT_TICKS    |
// |                  consecutive disagreeing samples                           |
// | Rev 1.0        : initial release                                           |
// +----------------------------------------------------------------------------+
module irrig_debounce #(
  parameter int FLT_TICKS = 2
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  i_tick,
  input  wire  i_din,
  output logic o_flt_nxt
);

  localparam logic [3:0] C_FLT = 4'(FLT_TICKS);

  logic       r_flt;
  logic       w_flt_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [3:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 4'd1;

  always_comb begin
    w_flt_nxt = r_flt;
    w_cnt_nxt = r_cnt;
    if (i_tick) begin
      if (i_din != r_flt) begin
        if (w_cnt_inc == C_FLT) begin
          w_flt_nxt = i_din;
          w_cnt_nxt = 4'd0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end else begin
        w_cnt_nxt = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flt <= 1'b0;
      r_cnt <= 4'd0;
    end else begin
      r_flt <= w_flt_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // The controller acts on the flip in the same tick it happens.
  assign o_flt_nxt = w_flt_nxt;

endmodule
`default_nettype wire

// File: rtl/irrigation_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | irrigation_ctrl : tick-paced irrigation FSM with inlet-valve hysteresis    |
// |                   and fault lock-out. Optional fill timeout alarm enabled  |
// |                   by defining IRRIG_FILL_TIMEOUT_EN.                       |
// | Rev 1.0         : initial release                                          |
// +----------------------------------------------------------------------------+
module irrigation_ctrl
  import irrig_pkg::*;
#(
  parameter int MIN_RUN      = C_MIN_RUN_DEF,
  parameter int MAX_RUN      = C_MAX_RUN_DEF,
  parameter int REST_TICKS   = C_REST_TICKS_DEF,
  parameter int FLT_TICKS    = C_FLT_TICKS_DEF,
  parameter int FILL_TIMEOUT = C_FILL_TOUT_DEF
) (
  input  wire              clk,
  input  wire              rst_n,
  irrigation_ctrl_if.slave bus
);

  localparam logic [C_CNT_W-1:0] C_MIN  = C_CNT_W'(MIN_RUN);
  localparam logic [C_CNT_W-1:0] C_MAX  = C_CNT_W'(MAX_RUN);
  localparam logic [C_CNT_W-1:0] C_REST = C_CNT_W'(REST_TICKS);
  localparam logic [C_CNT_W-1:0] C_FILL = C_CNT_W'(FILL_TIMEOUT);

  logic [6:0] r_sync1;
  logic [6:0] r_sync2;
  logic       w_low, w_mid, w_high, w_err, w_temp, w_usolo, w_uar;
  logic       w_flt;
  logic       w_unused;

  irrig_state_e       r_state;
  irrig_state_e       w_state_nxt;
  logic [C_CNT_W-1:0] r_cnt;
  logic [C_CNT_W-1:0] w_cnt_nxt;
  logic [C_CNT_W-1:0] w_cnt_inc;
  logic               r_valve;
  logic               w_valve_nxt;
  logic               w_fill_alm_nxt;
  logic               r_asp, r_got, r_vin, r_alm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {bus.low, bus.mid, bus.high, bus.erro_medida,
                  bus.temp, bus.usolo, bus.uar};
      r_sync2 <= r_sync1;
    end
  end

  assign {w_low, w_mid, w_high, w_err, w_temp, w_usolo, w_uar} = r_sync2;

  irrig_debounce #(
    .FLT_TICKS (FLT_TICKS)
  ) u_err_flt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_tick    (bus.tick),
    .i_din     (w_err),
    .o_flt_nxt (w_flt)
  );

  assign w_cnt_inc = sat_inc(r_cnt);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_valve_nxt = r_valve;
    if (bus.tick) begin
      // Valve is frozen while locked out; high wins over an empty reading.
      if (r_state != ST_FAULT) begin
        if (w_high)
          w_valve_nxt = 1'b0;
        else if (!w_low)
          w_valve_nxt = 1'b1;
      end

      if (w_flt) begin
        w_state_nxt = ST_FAULT;
        w_cnt_nxt   = '0;
      end else if (r_state == ST_FAULT) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else if (!w_low && (r_state != ST_IDLE)) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            w_cnt_nxt = '0;
            if (w_usolo && w_low)
              w_state_nxt = (w_temp || w_uar) ? ST_DRIP : ST_SPRINKLE;
          end
          ST_SPRINKLE, ST_DRIP: begin
            w_cnt_nxt = w_cnt_inc;
            if (((w_cnt_inc >= C_MIN) && !w_usolo) || (w_cnt_inc == C_MAX)) begin
              w_state_nxt = ST_REST;
              w_cnt_nxt   = '0;
            end
          end
          ST_REST: begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == C_REST) begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

`ifdef IRRIG_FILL_TIMEOUT_EN
  logic [C_CNT_W-1:0] r_fill;
  logic [C_CNT_W-1:0] w_fill_nxt;
  logic               r_fill_alm;

  // Counts consecutive open-valve ticks; the alarm latches until reset.
  always_comb begin
    w_fill_nxt     = r_fill;
    w_fill_alm_nxt = r_fill_alm;
    if (bus.tick) begin
      if (r_vin) begin
        w_fill_nxt = sat_inc(r_fill);
        if (w_fill_nxt == C_FILL)
          w_fill_alm_nxt = 1'b1;
      end else begin
        w_fill_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill     <= '0;
      r_fill_alm <= 1'b0;
    end else begin
      r_fill     <= w_fill_nxt;
      r_fill_alm <= w_fill_alm_nxt;
    end
  end

  assign w_unused = w_mid;
`else
  assign w_fill_alm_nxt = 1'b0;
  assign w_unused       = w_mid ^ (^C_FILL);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_valve <= 1'b0;
      r_asp   <= 1'b0;
      r_got   <= 1'b0;
      r_vin   <= 1'b0;
      r_alm   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valve <= w_valve_nxt;
      r_asp   <= (w_state_nxt == ST_SPRINKLE);
      r_got   <= (w_state_nxt == ST_DRIP);
      r_vin   <= w_valve_nxt && (w_state_nxt != ST_FAULT) && !w_fill_alm_nxt;
      r_alm   <= (w_state_nxt == ST_FAULT) || w_fill_alm_nxt;
    end
  end

  assign bus.aspersor    = r_asp;
  assign bus.gotejamento = r_got;
  assign bus.v_entrada   = r_vin;
  assign bus.alarme      = r_alm;
  assign bus.state       = r_state;

endmodule
`default_nettype wire

// File: doc/irrigation_ctrl.md
# irrigation_ctrl

Sequential irrigation and reservoir controller. It sits directly downstream of the tank-level error-detection stage and consumes its measurement-error flag together with the raw tank, temperature and humidity sensor bits. It drives the sprinkler, drip, inlet-valve and alarm outputs through a tick-paced state machine that enforces minimum run, maximum run and rest times. It also keeps inlet-valve hysteresis and holds a fault lock-out until the sensors are consistent again.

## Interface
- `MIN_RUN`, 4: minimum irrigation duration in ticks (1..255).
- `MAX_RUN`, 10: maximum irrigation duration in ticks (MIN_RUN..255).
- `REST_TICKS`, 3: mandatory pause after irrigation, in ticks (1..255).
- `FLT_TICKS`, 2: consecutive ticks the error flag must be stable to enter or leave FAULT (1..15).
- `FILL_TIMEOUT`, 20: maximum ticks with the inlet valve open before an alarm (only with the macro).
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle time-base strobe; all timing counts ticks.
- `low`, `mid`, `high`  in  1 each  tank level sensors; 1 = water at that level.
- `erro_medida`  in  1  inconsistent-level flag from the error-detection stage.
- `temp`  in  1  1 = high temperature.
- `usolo`  in  1  1 = soil dry (irrigation requested).
- `uar`  in  1  1 = air dry.
- `aspersor`  out  1  sprinkler on.
- `gotejamento`  out  1  drip on.
- `v_entrada`  out  1  inlet valve open.
- `alarme`  out  1  alarm.
- `state`  out  3  current FSM state code, for debug.

## Operation
- All sensor inputs pass through a 2-flop synchronizer. The `tick` input is not synchronized.
- All decisions happen only in cycles where `tick`=1. Counters increment only on tick cycles and saturate at 255.
- The error filter keeps a tick counter of consecutive sampled `erro_medida` values that differ from the filtered value. When it reaches FLT_TICKS, the filtered value flips and the counter clears. A matching sample clears the counter.
- FSM states: IDLE=0, SPRINKLE=1, DRIP=2, REST=3, FAULT=4.
- Priority order at each tick:
  1. Filtered error = 1 → FAULT, from any state.
  2. `low`=0 → IDLE, from SPRINKLE, DRIP or REST.
  3. State-specific rules below.
- IDLE:
  - If `usolo`=1 and `low`=1: go to DRIP when `temp`|`uar`, otherwise SPRINKLE.
  - The run counter clears.
- SPRINKLE / DRIP:
  - The run counter increments each tick.
  - Go to REST when run ≥ MIN_RUN and `usolo`=0, or when run = MAX_RUN.
  - The irrigation type is locked for the whole run.
- REST: the counter counts REST_TICKS, then the FSM goes to IDLE.
- FAULT:
  - Exit to IDLE when the filtered error returns to 0.
  - In FAULT, `aspersor`=`gotejamento`=`v_entrada`=0 and `alarme`=1.
- Inlet valve hysteresis, outside FAULT:
  - Set when `low`=0; clear when `high`=1.
  - If both `low`=0 and `high`=1 occur in the same tick, clear wins; the error stage flags that pattern.
  - The valve state is held across FAULT and is re-evaluated at the first tick after the FSM leaves FAULT.
- Actuator outputs: `aspersor` = (state==SPRINKLE), `gotejamento` = (state==DRIP). The two are never 1 simultaneously.

## Timing
- Reset values: all outputs 0, `state`=IDLE, all counters 0, filtered error 0, valve 0.
- Reset asserted mid-run stops the actuators immediately (asynchronous). Release takes effect on the next clock edge.
- Outputs are registered and change on the clock edge that ends the tick cycle.
- A sensor change is usable at the first tick occurring ≥2 cycles later (synchronizer latency).
- Fault entry takes FLT_TICKS ticks after `erro_medida` rises. Exit takes the same.
- Maximum irrigation length is exactly MAX_RUN ticks of output high. Minimum is MIN_RUN, unless the run is pre-empted by fault or empty tank.

## Configuration
- `IRRIG_FILL_TIMEOUT_EN` defined:
  - A fill counter counts ticks while `v_entrada`=1.
  - Reaching FILL_TIMEOUT forces `v_entrada`=0 and latches `alarme`=1 until reset.
  - The FSM continues operating.
- Undefined: no fill counter, and `alarme` is driven only by FAULT.

## Structure
- Package `irrig_pkg` holds:
  - the state enum and its 3-bit codes;
  - the counter width constant (8);
  - default timing constants.
- One sub-module, `irrig_debounce`: the tick-qualified FLT_TICKS stability filter used for `erro_medida`.

## Test plan
All tests use a tick every 4 cycles and default parameters.
- Reset, then `low`=`mid`=1, `usolo`=1, `temp`=`uar`=0 → SPRINKLE. Hold `usolo`=1 → `aspersor` high for exactly 10 ticks, then REST for 3 ticks, then IDLE, then a new run.
- `usolo` drops after 2 ticks of DRIP (`uar`=1) → `gotejamento` stays high until tick 4, then REST.
- `erro_medida` pulsed for 1 tick → no FAULT. Held for 2 ticks during SPRINKLE → FAULT, `alarme`=1, all actuators 0. Cleared for 2 ticks → IDLE.
- `low`=0 mid-run → IDLE and `v_entrada`=1. Then `low`=1 alone → valve stays open. Then `high`=1 → valve closes.
- `rst_n` asserted mid-DRIP → all outputs 0 within the same cycle, with no clock edge needed.
- With `IRRIG_FILL_TIMEOUT_EN`, `low`=0 held for 20 ticks → `v_entrada` drops and `alarme` stays latched until reset.
